vga_mem_ctrl: RTL and testbench

- Read-side initiator for the pixel memory (ROM) interface.
- Issues `addr`/`rd_en` reads to the memory, which returns data one cycle after `rd_en`, and captures the returns in a small prefetch FIFO.
- Presents pixel words to the VGA display pipeline on a pop-on-request basis.
- Reads run linearly through memory and wrap; `frame_start_in` restarts at address 0.

---
 rtl/vga_mem_ctrl.sv | 124 ++++++++++++
 tb/tb_vga_mem_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_ctrl.sv
// Read-side initiator for the pixel ROM. It issues linear, wrapping reads and
// prefetches the returned words into a small FIFO that the display pops on request.
module vga_mem_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable_in,
  input  logic                     frame_start_in,
  output logic [$clog2(DEPTH)-1:0] mem_addr_out,
  output logic                     mem_rd_en_out,
  input  logic [WIDTH-1:0]         mem_data_in,
  input  logic                     pix_req_in,
  output logic [WIDTH-1:0]         pix_data_out,
  output logic                     pix_valid_out,
  output logic                     underflow_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   addr_reg;
  logic            rd_en_reg, rd_en_next;
  logic            rd_pending_reg;
  logic            underflow_reg;
  logic [WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]     count_reg;
  logic [WIDTH-1:0] hold_reg;
  logic            push, pop, underflow_set;
  logic [CW-1:0]   occupancy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (frame_start_in) begin
      state_next = FLUSH;
    end else begin
      case (state_reg)
        IDLE:    if (enable_in)  state_next = FETCH;
        FETCH:   if (!enable_in) state_next = IDLE;
        FLUSH:   state_next = enable_in ? FETCH : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Occupancy counts stored words, the return on the bus and the read being issued;
  // a same-cycle pop is deliberately not credited so the FIFO can never overflow.
  always_comb begin
    occupancy     = CW'(count_reg) + CW'(rd_pending_reg) + CW'(rd_en_reg);
    rd_en_next    = (state_next == FETCH) && (occupancy < CW'(FIFO_DEPTH));
    push          = rd_pending_reg && !frame_start_in;
    pop           = pix_req_in && (count_reg != '0) && !frame_start_in;
    underflow_set = pix_req_in && (count_reg == '0) && !frame_start_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg       <= '0;
      rd_en_reg      <= 1'b0;
      rd_pending_reg <= 1'b0;
      underflow_reg  <= 1'b0;
    end else begin
      rd_en_reg      <= rd_en_next;
      rd_pending_reg <= frame_start_in ? 1'b0 : rd_en_reg;
      if (frame_start_in) begin
        addr_reg      <= '0;
        underflow_reg <= 1'b0;
      end else begin
        if (rd_en_reg)
          addr_reg <= (addr_reg == AW'(DEPTH - 1)) ? '0 : addr_reg + 1'b1;
        if (underflow_set)
          underflow_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= mem_data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      hold_reg   <= '0;
    end else if (frame_start_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        hold_reg   <= fifo_mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // While empty the output keeps the last popped word instead of stale storage.
  assign pix_data_out  = (count_reg == '0) ? hold_reg : fifo_mem[rd_ptr_reg];
  assign pix_valid_out = (count_reg != '0);
  assign mem_addr_out  = addr_reg;
  assign mem_rd_en_out = rd_en_reg;
  assign underflow_out = underflow_reg;

endmodule

// File: tb/tb_vga_mem_ctrl.sv
// Directed bench for vga_mem_ctrl: per-cycle vector table plus hand sequences for
// streaming with wrap, mid-stream frame restart and mid-stream reset.
module tb_vga_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable_in;
  logic       frame_start_in;
  logic [3:0] mem_addr_out;
  logic       mem_rd_en_out;
  logic [7:0] mem_data_in = 8'h00;
  logic       pix_req_in;
  logic [7:0] pix_data_out;
  logic       pix_valid_out;
  logic       underflow_out;

  int n_cmp = 0;
  int n_bad = 0;

  vga_mem_ctrl #(.WIDTH(8), .DEPTH(16), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable_in      (enable_in),
    .frame_start_in (frame_start_in),
    .mem_addr_out   (mem_addr_out),
    .mem_rd_en_out  (mem_rd_en_out),
    .mem_data_in    (mem_data_in),
    .pix_req_in     (pix_req_in),
    .pix_data_out   (pix_data_out),
    .pix_valid_out  (pix_valid_out),
    .underflow_out  (underflow_out)
  );

  always #5 clk = ~clk;

  // ROM model: mem[i] = A0 + i, one cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en_out) mem_data_in <= 8'hA0 + {4'h0, mem_addr_out};
  end

  typedef struct {
    logic       rst_n, en, fs, req;
    logic       exp_rd_en;
    logic [3:0] exp_addr;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_under;
    logic       chk_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, e, f, q, input logic rd, input logic [3:0] a,
                     input logic v, input logic [7:0] d, input logic u, input logic cd);
    vec_t t;
    t.rst_n = r; t.en = e; t.fs = f; t.req = q;
    t.exp_rd_en = rd; t.exp_addr = a; t.exp_valid = v;
    t.exp_data = d; t.exp_under = u; t.chk_data = cd;
    vecs.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string what, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h, want %0h", what, id, act, exp);
    end
  endtask

  task automatic check_all(input int id, input logic rd, input logic [3:0] a, input logic v,
                           input logic [7:0] d, input logic u, input logic cd);
    check("rd_en", id, 32'(mem_rd_en_out), 32'(rd));
    check("addr", id, 32'(mem_addr_out), 32'(a));
    check("valid", id, 32'(pix_valid_out), 32'(v));
    check("underflow", id, 32'(underflow_out), 32'(u));
    if (cd) check("data", id, 32'(pix_data_out), 32'(d));
    $display("step %0d: rd_en=%0b addr=%0d valid=%0b data=%02h uf=%0b",
             id, mem_rd_en_out, mem_addr_out, pix_valid_out, pix_data_out, underflow_out);
  endtask

  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      rst_n = vecs[i].rst_n; enable_in = vecs[i].en;
      frame_start_in = vecs[i].fs; pix_req_in = vecs[i].req;
      tick();
      check_all(i, vecs[i].exp_rd_en, vecs[i].exp_addr, vecs[i].exp_valid,
                vecs[i].exp_data, vecs[i].exp_under, vecs[i].chk_data);
    end
  endtask

  initial begin
    int seg1, seg2;
    rst_n = 1'b0; enable_in = 1'b0; frame_start_in = 1'b0; pix_req_in = 1'b0;

    // Reset, then idle with enable low.
    add(0,0,0,0, 0,4'd0,0,8'h00,0,1);
    add(0,0,0,0, 0,4'd0,0,8'h00,0,1);
    for (int i = 0; i < 10; i++) add(1,0,0,0, 0,4'd0,0,8'h00,0,1);
    // Fill with no pops: four reads, first valid two cycles after first rd_en.
    add(1,1,0,0, 1,4'd0,0,8'h00,0,1);
    add(1,1,0,0, 1,4'd1,0,8'h00,0,1);
    add(1,1,0,0, 1,4'd2,1,8'hA0,0,1);
    add(1,1,0,0, 1,4'd3,1,8'hA0,0,1);
    for (int i = 0; i < 4; i++) add(1,1,0,0, 0,4'd4,1,8'hA0,0,1);
    seg1 = vecs.size();
    // Underflow from an empty idle FIFO, sticky until frame_start.
    add(0,0,0,0, 0,4'd0,0,8'h00,0,1);
    add(0,0,0,0, 0,4'd0,0,8'h00,0,1);
    add(1,0,0,0, 0,4'd0,0,8'h00,0,1);
    add(1,0,0,1, 0,4'd0,0,8'h00,1,1);
    for (int i = 0; i < 3; i++) add(1,0,0,0, 0,4'd0,0,8'h00,1,1);
    add(1,0,1,0, 0,4'd0,0,8'h00,0,1);
    add(1,0,0,0, 0,4'd0,0,8'h00,0,1);
    add(1,0,0,0, 0,4'd0,0,8'h00,0,1);
    seg2 = vecs.size();

    run_vectors(0, seg1);

    // Continuous pops from a full FIFO: A0..AF then wrap to A0, A1 with no gaps.
    enable_in = 1'b1;
    pix_req_in = 1'b1;
    for (int i = 0; i < 18; i++) begin
      logic [7:0] want;
      want = 8'hA0 + 8'(i % 16);
      check("stream_valid", 100 + i, 32'(pix_valid_out), 32'd1);
      check("stream_data", 100 + i, 32'(pix_data_out), 32'(want));
      check("stream_uf", 100 + i, 32'(underflow_out), 32'd0);
      $display("pop %0d: data=%02h", i, pix_data_out);
      tick();
    end
    pix_req_in = 1'b0;

    run_vectors(seg1, seg2);

    // Frame restart while a return is in flight and head is A6.
    rst_n = 1'b0; tick();
    enable_in = 1'b1; rst_n = 1'b1;
    tick(); tick(); tick();
    check("fs_first", 200, 32'(pix_data_out), 32'hA0);
    pix_req_in = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("fs_head_valid", 201, 32'(pix_valid_out), 32'd1);
    check("fs_head", 202, 32'(pix_data_out), 32'hA6);
    frame_start_in = 1'b1; pix_req_in = 1'b0;
    tick();
    frame_start_in = 1'b0;
    check_all(203, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check_all(204, 1'b1, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check_all(205, 1'b1, 4'd1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check_all(206, 1'b1, 4'd2, 1'b1, 8'hA0, 1'b0, 1'b1);

    // Fill up, then reset mid-stream and restart from address 0.
    for (int i = 0; i < 6; i++) tick();
    check("full_valid", 300, 32'(pix_valid_out), 32'd1);
    check("full_addr", 301, 32'(mem_addr_out), 32'd4);
    rst_n = 1'b0;
    #1;
    check_all(302, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    check_all(303, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1);
    rst_n = 1'b1;
    tick();
    check_all(304, 1'b1, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    check_all(305, 1'b1, 4'd1, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    check_all(306, 1'b1, 4'd2, 1'b1, 8'hA0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
